// File: rtl/lvds_tx_pkg.sv
// Shared definitions for the LVDS transmit gearbox.
// Holds the link state encoding, the default training and idle lane patterns,
// and the width of the underflow counter.
package lvds_tx_pkg;

    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_TRAIN     = 2'd1,
        ST_RUN       = 2'd2
    } link_state_e;

    localparam logic [9:0] DEF_TRAIN_PAT = 10'h3E0;
    localparam logic [9:0] DEF_IDLE_PAT  = 10'h155;

    localparam int UFLOW_W = 16;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level.
// Ports:
//   I_clk - destination clock
//   I_rst - asynchronous active-high reset, clears both flops
//   I_d   - asynchronous input level
//   O_q   - synchronised level, two clock edges behind I_d
module sync_2ff (
    input  logic I_clk,
    input  logic I_rst,
    input  logic I_d,
    output logic O_q
);

    logic meta_q;
    logic sync_q;

    // First flop may go metastable; second flop gives it a full cycle to settle.
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= I_d;
            sync_q <= meta_q;
        end
    end

    assign O_q = sync_q;

endmodule

// File: rtl/lvds_tx_gearbox.sv
// LVDS transmit gearbox: accepts one WIDE-bit word per channel over a
// valid/ready handshake and slices it into RATIO beats of LANE_W bits for the
// serializer tx_in bus. Gates transmission on PLL lock, runs a training
// pattern phase before carrying data, and fills underflowed frames with an
// idle pattern while counting them.
// Ports:
//   I_clk           - serializer core clock
//   I_rst           - asynchronous active-high reset
//   I_tx_locked     - PLL lock, asynchronous to I_clk
//   I_train_req     - retrain request, sampled on the last beat of a frame
//   I_data          - channel c word at [c*WIDE +: WIDE]
//   I_valid         - I_data valid
//   O_ready         - I_data accepted this cycle when I_valid is high
//   O_tx_in         - channel c lane at [c*LANE_W +: LANE_W], registered
//   O_state         - 0 wait for lock, 1 training, 2 running
//   O_link_up       - high while running
//   O_underflow_cnt - saturating count of idle frames sent while running
module lvds_tx_gearbox
    import lvds_tx_pkg::*;
#(
    parameter int                NCH         = 9,
    parameter int                LANE_W      = 10,
    parameter int                RATIO       = 4,
    parameter int                TRAIN_BEATS = 256,
    parameter logic [LANE_W-1:0] TRAIN_PAT   = LANE_W'(DEF_TRAIN_PAT),
    parameter logic [LANE_W-1:0] IDLE_PAT    = LANE_W'(DEF_IDLE_PAT)
) (
    input  logic                      I_clk,
    input  logic                      I_rst,
    input  logic                      I_tx_locked,
    input  logic                      I_train_req,
    input  logic [NCH*LANE_W*RATIO-1:0] I_data,
    input  logic                      I_valid,
    output logic                      O_ready,
    output logic [NCH*LANE_W-1:0]     O_tx_in,
    output logic [1:0]                O_state,
    output logic                      O_link_up,
    output logic [UFLOW_W-1:0]        O_underflow_cnt
);

    localparam int WIDE   = LANE_W * RATIO;
    localparam int BEAT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int TCNT_W = (TRAIN_BEATS > 1) ? $clog2(TRAIN_BEATS) : 1;

    logic                  lock_s;
    link_state_e           state_q,    state_d;
    logic [BEAT_W-1:0]     beat_q,     beat_d;
    logic [TCNT_W-1:0]     tcnt_q,     tcnt_d;
    logic [NCH*WIDE-1:0]   hold_q,     hold_d;
    logic                  hold_vld_q, hold_vld_d;
    logic [NCH*WIDE-1:0]   shreg_q,    shreg_d;
    logic [NCH*LANE_W-1:0] tx_q,       tx_d;
    logic [UFLOW_W-1:0]    ucnt_q,     ucnt_d;
    logic                  link_up_q,  link_up_d;

    logic [NCH*LANE_W-1:0] hold_slice0;
    logic [NCH*LANE_W-1:0] shreg_slice;
    logic                  last_beat;
    logic                  ready;

    sync_2ff u_lock_sync (
        .I_clk (I_clk),
        .I_rst (I_rst),
        .I_d   (I_tx_locked),
        .O_q   (lock_s)
    );

    // Per-channel lane selection: slice 0 of the held word for a frame start,
    // and the slice for the current beat from the shift register otherwise.
    for (genvar c = 0; c < NCH; c++) begin : g_lane
        assign hold_slice0[c*LANE_W +: LANE_W] = hold_q[c*WIDE +: LANE_W];
        assign shreg_slice[c*LANE_W +: LANE_W] =
            shreg_q[c*WIDE + int'(beat_q)*LANE_W +: LANE_W];
    end

    assign last_beat = (beat_q == BEAT_W'(RATIO - 1));
    assign ready     = (state_q == ST_RUN) && !hold_vld_q;

    // Next-state logic. Loss of lock overrides everything, including a
    // handshake on the same edge. In RUN the output lags the beat counter by
    // one cycle, so the last slice of a frame is still sent on the edge that
    // enters TRAIN and the first cycle after TRAIN still shows the pattern.
    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        tcnt_d     = tcnt_q;
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        shreg_d    = shreg_q;
        tx_d       = tx_q;
        ucnt_d     = ucnt_q;

        if (!lock_s) begin
            state_d    = ST_WAIT_LOCK;
            beat_d     = '0;
            tcnt_d     = '0;
            hold_vld_d = 1'b0;
            shreg_d    = '0;
            tx_d       = '0;
        end else begin
            case (state_q)
                ST_WAIT_LOCK: begin
                    state_d = ST_TRAIN;
                    tx_d    = '0;
                end
                ST_TRAIN: begin
                    tx_d   = {NCH{TRAIN_PAT}};
                    beat_d = last_beat ? '0 : beat_q + 1'b1;
                    if (tcnt_q == TCNT_W'(TRAIN_BEATS - 1)) begin
                        state_d = ST_RUN;
                        tcnt_d  = '0;
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    beat_d = last_beat ? '0 : beat_q + 1'b1;
                    if (beat_q == '0) begin
                        if (hold_vld_q) begin
                            shreg_d    = hold_q;
                            hold_vld_d = 1'b0;
                            tx_d       = hold_slice0;
                        end else begin
                            // Fill the shift register with idle so the rest
                            // of the frame naturally repeats the idle pattern.
                            shreg_d = {NCH*RATIO{IDLE_PAT}};
                            tx_d    = {NCH{IDLE_PAT}};
                            if (ucnt_q != '1) begin
                                ucnt_d = ucnt_q + 1'b1;
                            end
                        end
                    end else begin
                        tx_d = shreg_slice;
                    end
                    if (I_valid && ready) begin
                        hold_d     = I_data;
                        hold_vld_d = 1'b1;
                    end
                    if (last_beat && I_train_req) begin
                        state_d = ST_TRAIN;
                    end
                end
                default: begin
                    state_d = ST_WAIT_LOCK;
                end
            endcase
        end

        link_up_d = (state_d == ST_RUN);
    end

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            state_q    <= ST_WAIT_LOCK;
            beat_q     <= '0;
            tcnt_q     <= '0;
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
            shreg_q    <= '0;
            tx_q       <= '0;
            ucnt_q     <= '0;
            link_up_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            tcnt_q     <= tcnt_d;
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
            shreg_q    <= shreg_d;
            tx_q       <= tx_d;
            ucnt_q     <= ucnt_d;
            link_up_q  <= link_up_d;
        end
    end

    assign O_ready         = ready;
    assign O_tx_in         = tx_q;
    assign O_state         = state_q;
    assign O_link_up       = link_up_q;
    assign O_underflow_cnt = ucnt_q;

endmodule

// File: tb/tb_lvds_tx_gearbox.sv
// Self-checking bench for lvds_tx_gearbox. A frame-level reference model
// predicts the lane stream as a queue of expected serializer words, plus the
// link state, ready and underflow count, and every cycle is compared. A second
// small instance (one beat per frame) is left idling long enough to saturate
// its underflow counter.
module tb_lvds_tx_gearbox;

    localparam int NCH    = 9;
    localparam int LANE_W = 10;
    localparam int RATIO  = 4;
    localparam int TBEATS = 8;
    localparam int WIDE   = LANE_W * RATIO;
    localparam int DW     = NCH * WIDE;
    localparam int TW     = NCH * LANE_W;
    localparam logic [LANE_W-1:0] TRAIN_PAT = 10'h3E0;
    localparam logic [LANE_W-1:0] IDLE_PAT  = 10'h155;

    logic          clk;
    logic          rst;
    logic          txLocked;
    logic          trainReq;
    logic [DW-1:0] data;
    logic          valid;
    logic          ready;
    logic [TW-1:0] txIn;
    logic [1:0]    state;
    logic          linkUp;
    logic [15:0]   uflow;

    logic          satRst;
    logic          satLocked;
    logic [9:0]    satData;
    logic          satValid;
    logic          satTrain;
    logic          satReady;
    logic [9:0]    satTxIn;
    logic [1:0]    satState;
    logic          satLinkUp;
    logic [15:0]   satUflow;

    int checksPassed = 0;
    int checksTotal  = 0;
    int cycleCount   = 0;

    // Reference model
    int            mState;
    int            mTick;
    int            mTrainCnt;
    logic [DW-1:0] mHold;
    logic          mHoldVld;
    logic [TW-1:0] mOut;
    int            mUflow;
    logic          mS1, mS2;
    logic [TW-1:0] expQ[$];

    lvds_tx_gearbox #(
        .NCH(NCH), .LANE_W(LANE_W), .RATIO(RATIO), .TRAIN_BEATS(TBEATS),
        .TRAIN_PAT(TRAIN_PAT), .IDLE_PAT(IDLE_PAT)
    ) dut (
        .I_clk           (clk),
        .I_rst           (rst),
        .I_tx_locked     (txLocked),
        .I_train_req     (trainReq),
        .I_data          (data),
        .I_valid         (valid),
        .O_ready         (ready),
        .O_tx_in         (txIn),
        .O_state         (state),
        .O_link_up       (linkUp),
        .O_underflow_cnt (uflow)
    );

    lvds_tx_gearbox #(
        .NCH(1), .LANE_W(10), .RATIO(1), .TRAIN_BEATS(2),
        .TRAIN_PAT(TRAIN_PAT), .IDLE_PAT(IDLE_PAT)
    ) dutSat (
        .I_clk           (clk),
        .I_rst           (satRst),
        .I_tx_locked     (satLocked),
        .I_train_req     (satTrain),
        .I_data          (satData),
        .I_valid         (satValid),
        .O_ready         (satReady),
        .O_tx_in         (satTxIn),
        .O_state         (satState),
        .O_link_up       (satLinkUp),
        .O_underflow_cnt (satUflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkEq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checksTotal++;
        assert (obs === exp) checksPassed++;
        else $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic modelReset();
        mState    = 0;
        mTick     = 0;
        mTrainCnt = 0;
        mHold     = '0;
        mHoldVld  = 1'b0;
        mOut      = '0;
        mUflow    = 0;
        mS1       = 1'b0;
        mS2       = 1'b0;
        expQ.delete();
    endtask

    // Advance the model by one clock edge given the inputs present at it.
    task automatic modelEdge(input logic inLock, input logic inValid,
                             input logic inTrain, input logic [DW-1:0] inData);
        logic          lockS;
        logic          readyBefore;
        int            prev;
        logic [TW-1:0] w;
        lockS = mS2;
        mS2   = mS1;
        mS1   = inLock;
        if (!lockS) begin
            mState    = 0;
            mTick     = 0;
            mTrainCnt = 0;
            mHoldVld  = 1'b0;
            mOut      = '0;
            expQ.delete();
        end else begin
            readyBefore = (mState == 2) && !mHoldVld;
            prev        = mState;
            if (mState == 2 && (mTick % RATIO) == 0) begin
                for (int b = 0; b < RATIO; b++) begin
                    for (int c = 0; c < NCH; c++)
                        w[c*LANE_W +: LANE_W] = mHoldVld ? mHold[c*WIDE + b*LANE_W +: LANE_W] : IDLE_PAT;
                    expQ.push_back(w);
                end
                if (!mHoldVld && mUflow < 65535) mUflow++;
                mHoldVld = 1'b0;
            end
            if (readyBefore && inValid) begin
                mHold    = inData;
                mHoldVld = 1'b1;
            end
            if (expQ.size() > 0) mOut = expQ.pop_front();
            else if (prev == 1)  mOut = {NCH{TRAIN_PAT}};
            else                 mOut = '0;
            case (prev)
                0: begin
                    mState    = 1;
                    mTick     = 0;
                    mTrainCnt = 0;
                end
                1: begin
                    mTick++;
                    mTrainCnt++;
                    if (mTrainCnt == TBEATS) begin
                        mState    = 2;
                        mTrainCnt = 0;
                    end
                end
                default: begin
                    if ((mTick % RATIO) == RATIO - 1 && inTrain) mState = 1;
                    mTick++;
                end
            endcase
        end
    endtask

    task automatic checkOutput();
        checkEq("tx_in",     DW'(txIn),   DW'(mOut));
        checkEq("state",     DW'(state),  DW'(mState));
        checkEq("link_up",   DW'(linkUp), DW'(mState == 2));
        checkEq("ready",     DW'(ready),  DW'((mState == 2) && !mHoldVld));
        checkEq("underflow", DW'(uflow),  DW'(mUflow));
    endtask

    task automatic applyStimulus(input logic lockIn, input logic validIn,
                                 input logic trainIn, input logic [DW-1:0] dataIn);
        txLocked = lockIn;
        valid    = validIn;
        trainReq = trainIn;
        data     = dataIn;
    endtask

    task automatic stepCycle();
        logic          l, v, t;
        logic [DW-1:0] d;
        l = txLocked;
        v = valid;
        t = trainReq;
        d = data;
        @(posedge clk);
        modelEdge(l, v, t, d);
        #1;
        cycleCount++;
        checkOutput();
    endtask

    task automatic waitRunBeat(input int target);
        int n;
        n = 0;
        while (!(mState == 2 && (mTick % RATIO) == target && !mHoldVld) && n < 40) begin
            stepCycle();
            n++;
        end
        checksTotal++;
        assert (n < 40) checksPassed++;
        else $error("[TB] FAIL wait_run_beat: waited=%0d limit=40", n);
    endtask

    function automatic logic [DW-1:0] randWord();
        logic [DW-1:0] w;
        w = '0;
        for (int i = 0; i < 12; i++) w = {w[DW-33:0], 32'($urandom())};
        return w;
    endfunction

    initial begin
        logic [DW-1:0] word;
        int            patCycles;
        int            lockLow;

        rst       = 1'b1;
        satRst    = 1'b1;
        satLocked = 1'b0;
        satData   = '0;
        satValid  = 1'b0;
        satTrain  = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, '0);
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        $display("[TB] reset state");
        checkOutput();
        checkEq("sat_reset_uflow", DW'(satUflow), '0);
        rst       = 1'b0;
        satRst    = 1'b0;
        satLocked = 1'b1;

        $display("[TB] lock and training");
        applyStimulus(1'b1, 1'b0, 1'b0, '0);
        patCycles = 0;
        for (int i = 0; i < 14; i++) begin
            stepCycle();
            if (txIn === {NCH{TRAIN_PAT}}) patCycles++;
        end
        checkEq("train_len", DW'(patCycles), DW'(TBEATS));
        checkEq("run_reached", DW'(state), DW'(2));

        $display("[TB] directed word");
        waitRunBeat(1);
        word = randWord();
        word[0 +: WIDE]         = {10'h0DD, 10'h0CC, 10'h0BB, 10'h0AA};
        word[8*WIDE +: WIDE]    = {10'h388, 10'h377, 10'h366, 10'h355};
        applyStimulus(1'b1, 1'b1, 1'b0, word);
        stepCycle();
        applyStimulus(1'b1, 1'b0, 1'b0, randWord());
        repeat (10) stepCycle();

        $display("[TB] back-to-back words");
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, randWord());
            stepCycle();
        end

        $display("[TB] three idle frames");
        applyStimulus(1'b1, 1'b0, 1'b0, '0);
        repeat (16) stepCycle();

        $display("[TB] lock loss with held word");
        waitRunBeat(1);
        applyStimulus(1'b1, 1'b1, 1'b0, randWord());
        stepCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, '0);
        repeat (4) stepCycle();
        checkEq("lock_lost_state", DW'(state), '0);
        checkEq("lock_lost_tx", DW'(txIn), '0);
        applyStimulus(1'b1, 1'b0, 1'b0, '0);
        repeat (24) stepCycle();

        $display("[TB] retrain with word held");
        waitRunBeat(1);
        applyStimulus(1'b1, 1'b1, 1'b1, randWord());
        stepCycle();
        applyStimulus(1'b1, 1'b0, 1'b1, '0);
        stepCycle();
        stepCycle();
        applyStimulus(1'b1, 1'b0, 1'b0, '0);
        checkEq("retrain_state", DW'(state), DW'(1));
        repeat (20) stepCycle();

        $display("[TB] randomized traffic");
        lockLow = 0;
        for (int i = 0; i < 600; i++) begin
            logic l;
            if (lockLow > 0) begin
                lockLow--;
                l = 1'b0;
            end else begin
                l = 1'b1;
                if ($urandom_range(0, 149) == 0) lockLow = $urandom_range(1, 5);
            end
            applyStimulus(l, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, randWord());
            stepCycle();
        end

        $display("[TB] asynchronous reset mid-operation");
        applyStimulus(1'b1, 1'b1, 1'b0, randWord());
        #3;
        rst = 1'b1;
        #1;
        modelReset();
        checkOutput();
        #1;
        rst = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, '0);
        repeat (30) stepCycle();

        $display("[TB] running idle until the small instance saturates");
        while (cycleCount < 70000) stepCycle();
        checkEq("sat_uflow", DW'(satUflow), DW'(16'hFFFF));
        checkEq("sat_state", DW'(satState), DW'(2));
        checkEq("sat_tx_idle", DW'(satTxIn), DW'(IDLE_PAT));

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
